// File: rtl/midi_stream_decoder_if.sv
// MIDI byte-stream bus: byte strobe in, note/CC/bend/error events out.
// master drives ready/MIDIbyte; slave (the decoder) drives the events.
interface midi_stream_decoder_if;
  logic        ready;
  logic [7:0]  MIDIbyte;
  logic        note_event_ready;
  logic        note_on;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic [3:0]  channel;
  logic        param_change_ready;
  logic [6:0]  param_idx;
  logic [6:0]  param_val;
  logic        bend_ready;
  logic [13:0] bend;
  logic        stream_error;

  modport master (
    output ready, MIDIbyte,
    input  note_event_ready, note_on, note, velocity, channel,
    input  param_change_ready, param_idx, param_val,
    input  bend_ready, bend, stream_error
  );

  modport slave (
    input  ready, MIDIbyte,
    output note_event_ready, note_on, note, velocity, channel,
    output param_change_ready, param_idx, param_val,
    output bend_ready, bend, stream_error
  );
endinterface

// File: rtl/midi_stream_decoder.sv
// 16-channel MIDI stream decoder: running status, channel mask, real-time
// transparency, SysEx skip. Ports: clk, reset_n, bus (slave modport).
module midi_stream_decoder #(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter bit          VEL0_IS_OFF  = 1'b1,
  parameter bit          BEND_EN      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  midi_stream_decoder_if.slave bus
);

  localparam logic [1:0] S_NO_STATUS = 2'd0;
  localparam logic [1:0] S_WAIT_D1   = 2'd1;
  localparam logic [1:0] S_WAIT_D2   = 2'd2;
  localparam logic [1:0] S_SYSEX     = 2'd3;

  localparam logic [15:0] CH_MASK = CHANNEL_MASK;

  logic [1:0]  r_state;
  logic [7:0]  r_status;
  logic [6:0]  r_d1;

  logic        r_note_rdy;
  logic        r_note_on;
  logic [6:0]  r_note;
  logic [6:0]  r_vel;
  logic [3:0]  r_chan;
  logic        r_cc_rdy;
  logic [6:0]  r_cc_idx;
  logic [6:0]  r_cc_val;
  logic        r_bend_rdy;
  logic [13:0] r_bend;
  logic        r_err;

  logic [7:0]  w_b;
  logic        w_rdy;
  logic        w_rt;
  logic        w_chs;
  logic        w_f0;
  logic        w_sys;
  logic        w_dat;
  logic [3:0]  w_kind;
  logic        w_one;
  logic        w_ch_ok;
  logic        w_fin;
  logic        w_note;
  logic        w_cc;
  logic        w_bnd;
  logic        w_err;
  logic        w_any;
  logic        w_on;

  assign w_b   = bus.MIDIbyte;
  assign w_rdy = bus.ready;

  // Byte classes partition 00-FF, so exactly one is set.
  assign w_rt  = (w_b[7:3] == 5'b11111);
  assign w_f0  = (w_b == 8'hF0);
  assign w_sys = (w_b[7:3] == 5'b11110) && !w_f0;
  assign w_chs = w_b[7] && (w_b[7:4] != 4'hF);
  assign w_dat = !w_b[7];

  assign w_kind  = r_status[7:4];
  assign w_one   = (w_kind == 4'hC) || (w_kind == 4'hD);
  assign w_ch_ok = CH_MASK[r_status[3:0]];

  // Final data byte of a two-byte message on an accepted channel.
  assign w_fin  = w_rdy && w_dat && (r_state == S_WAIT_D2) && w_ch_ok;
  assign w_note = w_fin && ((w_kind == 4'h8) || (w_kind == 4'h9));
  assign w_cc   = w_fin && (w_kind == 4'hB);
  assign w_bnd  = w_fin && (w_kind == 4'hE) && BEND_EN;
  assign w_err  = w_rdy && w_dat && (r_state == S_NO_STATUS);
  assign w_any  = w_note || w_cc || w_bnd;

  assign w_on = (w_kind == 4'h9) &&
                !(VEL0_IS_OFF && (w_b[6:0] == 7'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_NO_STATUS;
      r_status <= 8'h00;
      r_d1     <= 7'h00;
    end else if (w_rdy) begin
      unique case (1'b1)
        w_rt: begin
        end
        w_chs: begin
          r_status <= w_b;
          r_state  <= S_WAIT_D1;
        end
        w_f0: begin
          r_status <= 8'h00;
          r_state  <= S_SYSEX;
        end
        w_sys: begin
          // Inside SysEx only F7 ends it; F1-F6 are skipped.
          if (r_state == S_SYSEX) begin
            if (w_b == 8'hF7)
              r_state <= S_NO_STATUS;
          end else begin
            r_status <= 8'h00;
            r_state  <= S_NO_STATUS;
          end
        end
        w_dat: begin
          unique case (r_state)
            S_WAIT_D1: begin
              if (!w_one) begin
                r_d1    <= w_b[6:0];
                r_state <= S_WAIT_D2;
              end
            end
            S_WAIT_D2: r_state <= S_WAIT_D1;
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_note_rdy <= 1'b0;
      r_note_on  <= 1'b0;
      r_note     <= 7'h00;
      r_vel      <= 7'h00;
      r_chan     <= 4'h0;
      r_cc_rdy   <= 1'b0;
      r_cc_idx   <= 7'h00;
      r_cc_val   <= 7'h00;
      r_bend_rdy <= 1'b0;
      r_bend     <= 14'h2000;
      r_err      <= 1'b0;
    end else begin
      r_note_rdy <= w_note;
      r_cc_rdy   <= w_cc;
      r_bend_rdy <= w_bnd;
      r_err      <= w_err;
      if (w_note) begin
        r_note_on <= w_on;
        r_note    <= r_d1;
        r_vel     <= w_b[6:0];
      end
      if (w_cc) begin
        r_cc_idx <= r_d1;
        r_cc_val <= w_b[6:0];
      end
      if (w_bnd)
        r_bend <= {w_b[6:0], r_d1};
      if (w_any)
        r_chan <= r_status[3:0];
    end
  end

  assign bus.note_event_ready   = r_note_rdy;
  assign bus.note_on            = r_note_on;
  assign bus.note               = r_note;
  assign bus.velocity           = r_vel;
  assign bus.channel            = r_chan;
  assign bus.param_change_ready = r_cc_rdy;
  assign bus.param_idx          = r_cc_idx;
  assign bus.param_val          = r_cc_val;
  assign bus.bend_ready         = r_bend_rdy;
  assign bus.bend               = r_bend;
  assign bus.stream_error       = r_err;

endmodule

// File: doc/midi_stream_decoder.md
Name: midi_stream_decoder

Overview:
- Parametrised successor to the single-channel MIDI byte decoder.
- Consumes the serial-to-parallel MIDI byte stream, one byte per `ready` strobe.
- Decodes note-on/off, control change and pitch bend across all 16 channels, with:
  - running status
  - a per-channel acceptance mask
  - real-time byte transparency
  - SysEx skipping
- Feeds the voice allocator (note events) and the parameter updater (CC/bend events).

Parameters:
- CHANNEL_MASK, 16'hFFFF, bit n=1 accepts MIDI channel n; events on masked channels are consumed silently.
- VEL0_IS_OFF, 1, when 1 a note-on with velocity 0 is reported as note-off.
- BEND_EN, 1, when 0 pitch-bend messages are consumed with no output.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- ready  input  1  one-cycle strobe, MIDIbyte valid
- MIDIbyte  input  8  received MIDI byte
- note_event_ready  output  1  one-cycle pulse, note fields valid
- note_on  output  1  1=note-on, 0=note-off
- note  output  7  note number
- velocity  output  7  velocity
- channel  output  4  channel of the most recent reported event (any type)
- param_change_ready  output  1  one-cycle pulse, CC fields valid
- param_idx  output  7  controller number
- param_val  output  7  controller value
- bend_ready  output  1  one-cycle pulse, bend valid
- bend  output  14  pitch bend, {MSB,LSB}, centre 14'h2000
- stream_error  output  1  one-cycle pulse on orphan data byte

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchroniser): all outputs 0 except bend=14'h2000. State=NO_STATUS, running status cleared.
- Only cycles with ready=1 advance state; MIDIbyte is ignored otherwise.
- States:
  - NO_STATUS, WAIT_D1, WAIT_D2, SYSEX.
  - Registers held across states: status[7:0] (running status) and d1[6:0].
- Real-time bytes F8–FF: ignored in every state, no state or register change, never interrupt a message.
- Channel status byte 80–EF: accepted in any state; aborts any partial message.
  - Loads status and goes to WAIT_D1.
  - A byte received in SYSEX is also accepted this way and exits SYSEX.
- F0: goes to SYSEX and clears running status.
  - All data bytes are discarded with no error until F7 or any status byte 80–EF.
  - F7 returns to NO_STATUS.
- F1–F7 outside SYSEX: clear running status and go to NO_STATUS.
- Data byte in NO_STATUS: discarded and pulses stream_error; state unchanged.
- Data byte in WAIT_D1:
  - Two-byte kinds 8n, 9n, An, Bn, En: store d1, go to WAIT_D2.
  - One-byte kinds Cn, Dn: message complete (no output), stay in WAIT_D1.
- Data byte in WAIT_D2: message complete, return to WAIT_D1 (running status retained).
  - If CHANNEL_MASK[status[3:0]]=1, emit the event below; otherwise emit nothing.
  - 8n: note_on=0, note=d1, velocity=byte.
  - 9n: note_on = !(VEL0_IS_OFF && byte==0), note=d1, velocity=byte.
  - Bn: param_idx=d1, param_val=byte.
  - En (BEND_EN=1): bend={byte,d1}.
  - An: nothing.
- Latency: the event pulse and its fields are registered and appear the cycle after the ready cycle carrying the final data byte.
- Pulse and field behaviour:
  - At most one of the three event pulses is high per cycle.
  - Fields of a given type change only when that type's pulse fires and hold otherwise.
  - channel updates on every emitted pulse.
- Back-to-back ready on consecutive cycles must be supported with no lost bytes.

Test Plan:
- 90 45 67 -> one note_event_ready; note_on=1, note=7'h45, velocity=7'h67, channel=0; one cycle after the third ready.
- 93 3C 40 3C 00 with VEL0_IS_OFF=1 -> two pulses: (on, 3C, 40, ch 3) then running-status (off, 3C, 00, ch 3).
- B0 15 65, then B0 1B 67, then B0 68 68 -> three param_change_ready pulses: (15,65), (1B,67), (68,68); no note pulse.
- 90 45 F8 67 -> F8 ignored; single note-on (45,67). Then F0 12 34 F7 45 -> no event, exactly one stream_error (on 45).
- E2 00 40 -> bend_ready, bend=14'h2000, channel=2. Then CHANNEL_MASK=16'h0001 run with 91 40 7F -> no pulse, decoder stays in WAIT_D1.
- reset_n low after 90 45 -> outputs cleared immediately; subsequent 67 gives stream_error and no note event.
